// File: rtl/muldiv_unit.sv
// Iterative RV32/64 M-extension multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// Define MULDIV_UNIT_DIV_EN to build the divider; without it ops 1xx complete immediately with invalid_op set.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            SYS_clk,
  input  logic            SYS_reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            invalid_op,
  output logic            busy
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_count;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_a;
  logic [2*XLEN-1:0] r_acc;
  logic              r_negRes;
  logic              r_special;
  logic              r_specialInv;
  logic [XLEN-1:0]   r_specialRes;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [XLEN-1:0]   r_result;
  logic              r_invalid_op;
  logic              r_busy;

  logic              w_rs1Neg;
  logic              w_rs2Neg;
  logic [XLEN-1:0]   w_absA;
  logic [XLEN-1:0]   w_absB;
  logic [XLEN:0]     w_mulSum;
  logic [2*XLEN-1:0] w_mulNext;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_mulRes;
  logic [2*XLEN-1:0] w_step;
  logic [XLEN-1:0]   w_fixRes;
  logic              w_special;
  logic              w_specialInv;
  logic [XLEN-1:0]   w_specialRes;

  // Operand signedness: mulh/div/rem treat both as signed, mulhsu only rs1.
  assign w_rs1Neg = rs1_data[XLEN-1] &&
                    (op == 3'b001 || op == 3'b010 || op == 3'b100 || op == 3'b110);
  assign w_rs2Neg = rs2_data[XLEN-1] && (op == 3'b001 || op == 3'b100 || op == 3'b110);
  assign w_absA   = w_rs1Neg ? -rs1_data : rs1_data;
  assign w_absB   = w_rs2Neg ? -rs2_data : rs2_data;

  // Accumulator holds {partial product, remaining multiplier bits}.
  assign w_mulSum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_a : {XLEN{1'b0}})};
  assign w_mulNext = {w_mulSum, r_acc[XLEN-1:1]};
  assign w_prod    = r_negRes ? -r_acc : r_acc;
  assign w_mulRes  = (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

`ifdef MULDIV_UNIT_DIV_EN
  logic [XLEN-1:0]   r_b;
  logic              r_negRem;
  logic [XLEN:0]     w_divShift;
  logic [XLEN:0]     w_divDiff;
  logic [2*XLEN-1:0] w_divNext;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic              w_divZero;
  logic              w_ovf;

  // Accumulator holds {partial remainder, dividend bits becoming quotient bits}.
  assign w_divShift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_divDiff  = w_divShift - {1'b0, r_b};
  assign w_divNext  = w_divDiff[XLEN] ? {w_divShift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                      : {w_divDiff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
  assign w_quo      = r_negRes ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem      = r_negRem ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  assign w_step   = r_op[2] ? w_divNext : w_mulNext;
  assign w_fixRes = r_op[2] ? (r_op[1] ? w_rem : w_quo) : w_mulRes;

  // Divide by zero and signed overflow bypass the iteration with fixed results.
  assign w_divZero    = (rs2_data == {XLEN{1'b0}});
  assign w_ovf        = !op[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
                        (rs2_data == {XLEN{1'b1}});
  assign w_special    = op[2] && (w_divZero || w_ovf);
  assign w_specialInv = 1'b0;
  assign w_specialRes = w_divZero ? (op[1] ? rs1_data : {XLEN{1'b1}})
                                  : (op[1] ? {XLEN{1'b0}} : rs1_data);
`else
  assign w_step       = w_mulNext;
  assign w_fixRes     = r_op[2] ? {XLEN{1'b0}} : w_mulRes;
  assign w_special    = op[2];
  assign w_specialInv = 1'b1;
  assign w_specialRes = {XLEN{1'b0}};
`endif

  // out_valid trails DONE entry by one edge so a result is never presented in the cycle it is written.
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_special    <= 1'b0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_result     <= '0;
      r_invalid_op <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op         <= op;
            r_a          <= w_absA;
            r_negRes     <= w_rs1Neg ^ w_rs2Neg;
            r_acc        <= op[2] ? {{XLEN{1'b0}}, w_absA} : {{XLEN{1'b0}}, w_absB};
`ifdef MULDIV_UNIT_DIV_EN
            r_b          <= w_absB;
            r_negRem     <= w_rs1Neg;
`endif
            r_count      <= CW'(XLEN);
            r_special    <= w_special;
            r_specialInv <= w_specialInv;
            r_specialRes <= w_specialRes;
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= w_special ? FIX : CALC;
          end
        end
        CALC: begin
          r_acc   <= w_step;
          r_count <= r_count - CW'(1);
          if (r_count == CW'(1)) r_state <= FIX;
        end
        FIX: begin
          r_result     <= r_special ? r_specialRes : w_fixRes;
          r_invalid_op <= r_special && r_specialInv;
          r_state      <= DONE;
        end
        DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign result     = r_result;
  assign invalid_op = r_invalid_op;
  assign busy       = r_busy;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL provide parameter XLEN, default 32, giving operand and result width; legal values are 8 to 64 and even.
REQ-002 SHALL provide SYS_clk  input  1  as the single clock; all state updates on its rising edge.
REQ-003 SHALL provide SYS_reset  input  1  as the reset; it is synchronous and active-high.
REQ-004 SHALL provide in_valid  input  1  to indicate that a request is present.
REQ-005 SHALL provide in_ready  output  1  to indicate the unit can accept a request.
REQ-006 SHALL provide op  input  3  selecting the M-extension funct3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
REQ-007 SHALL provide rs1_data  input  XLEN  as the dividend or multiplicand.
REQ-008 SHALL provide rs2_data  input  XLEN  as the divisor or multiplier.
REQ-009 SHALL provide out_valid  output  1  to indicate that result is valid.
REQ-010 SHALL provide out_ready  input  1  to indicate the consumer accepts the result.
REQ-011 SHALL provide result  output  XLEN  carrying the operation result.
REQ-012 SHALL provide invalid_op  output  1  to flag an op that is not supported in this build; it is qualified by out_valid.
REQ-013 SHALL provide busy  output  1  driven high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM IDLE -> CALC -> FIX -> DONE -> IDLE.
REQ-015 SHALL drive in_ready = (state == IDLE); a request is accepted on an edge where in_valid and in_ready are both high.
REQ-016 On acceptance, SHALL latch op and operands, latch absolute values per signedness, set iteration counter = XLEN, and enter CALC.
REQ-017 In CALC, SHALL perform one radix-2 step per cycle: shift-add for multiply over a 2*XLEN accumulator, restoring subtraction for divide; the counter decrements each cycle and the state goes to FIX when the counter reaches 1.
REQ-018 In FIX, SHALL apply sign correction (two's complement negation of the product, quotient or remainder as required) and select the lower or upper XLEN bits, then go to DONE.
REQ-019 out_valid SHALL rise exactly XLEN+2 edges after the accepting edge for normal operations.
REQ-020 Divide by zero SHALL skip CALC and reach DONE 2 edges after acceptance with quotient = all ones and remainder = rs1_data.
REQ-021 Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1, div or rem) SHALL skip CALC, reach DONE in 2 edges, and return quotient = rs1_data, remainder = 0.
REQ-022 Division results SHALL round toward zero; the remainder sign SHALL follow the dividend.
REQ-023 In DONE, result and invalid_op SHALL be held stable while out_ready is low; on out_valid && out_ready the unit returns to IDLE. There is no same-cycle re-accept, so in_ready is high on the next cycle.
REQ-024 in_valid SHALL be ignored while not in IDLE; operand changes after acceptance SHALL have no effect.

Reset
REQ-025 While SYS_reset is high at an edge, SHALL go to IDLE, drive out_valid=0, result=0, invalid_op=0, busy=0, in_ready=1, and clear the counter.
REQ-026 Reset asserted mid-operation (CALC, FIX or DONE) SHALL abort the operation; no result is delivered.

Configuration
REQ-027 Macro MULDIV_UNIT_DIV_EN SHALL control divide support.
REQ-028 With MULDIV_UNIT_DIV_EN defined, SHALL support all eight ops.
REQ-029 Without MULDIV_UNIT_DIV_EN, SHALL exclude the divider logic; ops 1xx go directly to DONE 2 edges after acceptance with result=0 and invalid_op=1, and multiply behaviour is unchanged.

Verification (XLEN=32)
REQ-030 Bench SHALL cover: mul 7, 0xFFFFFFFD -> result 0xFFFFFFEB, out_valid exactly 34 edges after accept.
REQ-031 Bench SHALL cover: mulh 0x80000000, 0x80000000 -> 0x40000000; mulhu 0xFFFFFFFF, 0xFFFFFFFF -> 0xFFFFFFFE; mulhsu 0xFFFFFFFF, 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-032 Bench SHALL cover: div 0xFFFFFFF9, 2 -> 0xFFFFFFFD; rem same operands -> 0xFFFFFFFF; divu 100, 7 -> 14; remu 100, 7 -> 2.
REQ-033 Bench SHALL cover: div 5, 0 -> 0xFFFFFFFF and rem 5, 0 -> 5, each within 2 edges; div 0x80000000, 0xFFFFFFFF -> 0x80000000 and rem -> 0.
REQ-034 Bench SHALL cover: out_ready held low 10 cycles after out_valid -> result, out_valid and in_ready stable; accept then in_ready=1 next cycle.
REQ-035 Bench SHALL cover: SYS_reset pulsed at CALC cycle 10 -> out_valid never rises, in_ready=1 after the reset edge, and the next mul 3, 4 returns 12.
